window_line_buffer: RTL and testbench

Parametrised line buffer for the convolution datapath. It stores `ROWS` image rows of `ROW_BYTES` bytes each and accepts byte-swapped words over a ready/valid write port. It tracks row occupancy itself and presents a `ROWS x WIN_BYTES` byte window at any column. It supersedes the fixed 4-row / 16-byte / 4-byte-window buffer, adding auto-incrementing fill, occupancy flags, flush, and defined column-overrun behaviour.

---
 rtl/wlb_pkg.sv | 35 +++
 rtl/window_line_buffer_if.sv | 13 +
 rtl/wlb_window_mux.sv | 31 +++
 rtl/window_line_buffer.sv | 112 +++++++++++
 tb/tb_window_line_buffer.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wlb_pkg.sv
// Shared definitions for window_line_buffer.
// Holds default parameter values, the index-width helper used for rd_col,
// rows_full and internal pointers, and the byte_swap function that turns an
// MSB-first write word into byte-index order.
package wlb_pkg;

  localparam int unsigned DefRows      = 4;
  localparam int unsigned DefRowBytes  = 16;
  localparam int unsigned DefWordBytes = 4;
  localparam int unsigned DefWinBytes  = 4;

  // byte_swap works on a fixed container; WORD_BYTES must not exceed this.
  localparam int unsigned MaxWordBytes = 32;
  localparam int unsigned MaxWordW     = MaxWordBytes * 8;

  // Width of an index able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Reverse the lowest nbytes bytes of w: the MSB byte of the word becomes
  // byte 0 of the result, so result byte k belongs at address base+k.
  function automatic logic [MaxWordW-1:0] byte_swap(input logic [MaxWordW-1:0] w,
                                                    input int unsigned nbytes);
    logic [MaxWordW-1:0] res;
    res = '0;
    for (int unsigned k = 0; k < MaxWordBytes; k++) begin
      if (k < nbytes) begin
        res[k*8 +: 8] = w[(nbytes-1-k)*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/window_line_buffer_if.sv
// Write port of window_line_buffer: ready/valid handshake plus data word.
// master: producer drives wr_valid/wr_data, samples wr_ready.
// slave : line buffer samples wr_valid/wr_data, drives wr_ready.
interface window_line_buffer_if #(
  parameter int unsigned WORD_BYTES = 4
);
  logic                    wr_valid;
  logic                    wr_ready;
  logic [WORD_BYTES*8-1:0] wr_data;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/wlb_window_mux.sv
// Selects WIN_BYTES consecutive bytes of one stored row starting at rd_col_i.
// Ports: row_i (row, byte b at [b*8 +: 8]), rd_col_i (start byte),
//        win_o (byte j at [j*8 +: 8] = row byte rd_col_i+j).
// Bytes past the end of the row read as 0x00 when WLB_ZERO_PAD_EN is defined;
// otherwise the byte index wraps modulo ROW_BYTES.
module wlb_window_mux
  import wlb_pkg::*;
#(
  parameter int unsigned ROW_BYTES = DefRowBytes,
  parameter int unsigned WIN_BYTES = DefWinBytes
) (
  input  logic [ROW_BYTES*8-1:0]        row_i,
  input  logic [idx_w(ROW_BYTES)-1:0]   rd_col_i,
  output logic [WIN_BYTES*8-1:0]        win_o
);

  always_comb begin
    win_o = '0;
    for (int unsigned j = 0; j < WIN_BYTES; j++) begin
      automatic int unsigned idx = int'(rd_col_i) + j;
`ifdef WLB_ZERO_PAD_EN
      if (idx < ROW_BYTES) begin
        win_o[j*8 +: 8] = row_i[idx*8 +: 8];
      end
`else
      win_o[j*8 +: 8] = row_i[(idx % ROW_BYTES)*8 +: 8];
`endif
    end
  end

endmodule

// File: rtl/window_line_buffer.sv
// Line buffer for the convolution datapath: ROWS rows of ROW_BYTES bytes,
// filled word by word over a ready/valid port, read as a ROWS x WIN_BYTES
// byte window at any column.
// Ports: clk, rst (async, active-high), flush (sync clear of occupancy and
//        pointers), wr (write handshake interface, slave side), shift_up
//        (drop row 0), rd_col (window column), rd_window (row r at
//        [r*WIN_BYTES*8 +: WIN_BYTES*8]), win_valid (all rows full),
//        rows_full (completely filled rows).
// Build option: define WLB_ZERO_PAD_EN for zero padding past the right edge
// of a row instead of wrap-around.
module window_line_buffer
  import wlb_pkg::*;
#(
  parameter int unsigned ROWS       = DefRows,
  parameter int unsigned ROW_BYTES  = DefRowBytes,
  parameter int unsigned WORD_BYTES = DefWordBytes,
  parameter int unsigned WIN_BYTES  = DefWinBytes
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  window_line_buffer_if.slave             wr,
  input  logic                            shift_up,
  input  logic [idx_w(ROW_BYTES)-1:0]     rd_col,
  output logic [ROWS*WIN_BYTES*8-1:0]     rd_window,
  output logic                            win_valid,
  output logic [idx_w(ROWS+1)-1:0]        rows_full
);

  localparam int unsigned CntW  = idx_w(ROWS + 1);
  localparam int unsigned PtrW  = idx_w(ROW_BYTES);
  localparam int unsigned RowW  = idx_w(ROWS);
  localparam int unsigned WordW = WORD_BYTES * 8;
  localparam int unsigned RowBits = ROW_BYTES * 8;

  logic [RowBits-1:0] row_q [ROWS];
  logic [RowBits-1:0] row_d [ROWS];
  logic [CntW-1:0]    rows_full_q, rows_full_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;

  logic             wr_ready_int;
  logic             wr_fire;
  logic             shift_ok;
  logic             row_done;
  logic [RowW-1:0]  fill_idx;
  logic [WordW-1:0] wr_swapped;

  assign wr_ready_int = (rows_full_q < CntW'(ROWS)) && !flush;
  assign wr.wr_ready  = wr_ready_int;
  assign wr_fire      = wr.wr_valid && wr_ready_int;
  assign shift_ok     = shift_up && (rows_full_q != '0);
  assign row_done     = wr_fire && (wr_ptr_q == PtrW'(ROW_BYTES - WORD_BYTES));
  // With a simultaneous shift the fill row has already moved up by one.
  assign fill_idx     = RowW'(rows_full_q - CntW'(shift_ok));
  assign wr_swapped   = WordW'(byte_swap(MaxWordW'(wr.wr_data), WORD_BYTES));

  always_comb begin
    row_d       = row_q;
    rows_full_d = rows_full_q;
    wr_ptr_d    = wr_ptr_q;
    if (flush) begin
      // Storage is kept; only occupancy and the write pointer restart.
      rows_full_d = '0;
      wr_ptr_d    = '0;
    end else begin
      if (shift_ok) begin
        for (int unsigned i = 0; i < ROWS - 1; i++) begin
          row_d[i] = row_q[i+1];
        end
        row_d[ROWS-1] = '0;
      end
      if (wr_fire) begin
        for (int unsigned k = 0; k < WORD_BYTES; k++) begin
          row_d[fill_idx][(int'(wr_ptr_q) + k)*8 +: 8] = wr_swapped[k*8 +: 8];
        end
        wr_ptr_d = row_done ? '0 : wr_ptr_q + PtrW'(WORD_BYTES);
      end
      rows_full_d = rows_full_q + CntW'(row_done) - CntW'(shift_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_full_q <= '0;
      wr_ptr_q    <= '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        row_q[r] <= '0;
      end
    end else begin
      rows_full_q <= rows_full_d;
      wr_ptr_q    <= wr_ptr_d;
      for (int unsigned r = 0; r < ROWS; r++) begin
        row_q[r] <= row_d[r];
      end
    end
  end

  assign rows_full = rows_full_q;
  assign win_valid = (rows_full_q == CntW'(ROWS));

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    wlb_window_mux #(
      .ROW_BYTES (ROW_BYTES),
      .WIN_BYTES (WIN_BYTES)
    ) u_mux (
      .row_i    (row_q[r]),
      .rd_col_i (rd_col),
      .win_o    (rd_window[r*WIN_BYTES*8 +: WIN_BYTES*8])
    );
  end

endmodule

// File: tb/tb_window_line_buffer.sv
module tb_window_line_buffer;
  localparam int ROWS = 4;
  localparam int RB   = 16;
  localparam int WB   = 4;
  localparam int WIN  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         shift_up;
  logic [3:0]   rd_col;
  logic [127:0] rd_window;
  logic         win_valid;
  logic [2:0]   rows_full;

  window_line_buffer_if #(.WORD_BYTES(WB)) wr_if ();

  window_line_buffer #(
    .ROWS       (ROWS),
    .ROW_BYTES  (RB),
    .WORD_BYTES (WB),
    .WIN_BYTES  (WIN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr        (wr_if.slave),
    .shift_up  (shift_up),
    .rd_col    (rd_col),
    .rd_window (rd_window),
    .win_valid (win_valid),
    .rows_full (rows_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: byte-addressed rows, occupancy count, byte pointer.
  logic [7:0] m [ROWS][RB];
  int m_rows;
  int m_ptr;

  function automatic void mdl_clear();
    for (int r = 0; r < ROWS; r++) for (int b = 0; b < RB; b++) m[r][b] = 8'h00;
    m_rows = 0;
    m_ptr  = 0;
  endfunction

  function automatic void mdl_step(input logic f, input logic v, input logic [31:0] d,
                                   input logic s);
    int sh, fire, tgt;
    if (f) begin
      m_rows = 0;
      m_ptr  = 0;
      return;
    end
    sh   = (s && m_rows > 0) ? 1 : 0;
    fire = (v && m_rows < ROWS) ? 1 : 0;
    if (sh != 0) begin
      for (int r = 0; r < ROWS - 1; r++) for (int b = 0; b < RB; b++) m[r][b] = m[r+1][b];
      for (int b = 0; b < RB; b++) m[ROWS-1][b] = 8'h00;
    end
    if (fire != 0) begin
      tgt = m_rows - sh;
      for (int k = 0; k < WB; k++) m[tgt][m_ptr+k] = d[31-8*k -: 8];
      m_ptr = m_ptr + WB;
      if (m_ptr == RB) begin
        m_ptr  = 0;
        m_rows = m_rows + 1;
      end
    end
    m_rows = m_rows - sh;
  endfunction

  function automatic logic [127:0] exp_win(input int col);
    logic [127:0] w;
    w = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int j = 0; j < WIN; j++) begin
        if (col + j < RB) w[(r*WIN+j)*8 +: 8] = m[r][col+j];
`ifdef WLB_ZERO_PAD_EN
        else w[(r*WIN+j)*8 +: 8] = 8'h00;
`else
        else w[(r*WIN+j)*8 +: 8] = m[r][col+j-RB];
`endif
      end
    end
    return w;
  endfunction

  function automatic logic [31:0] swap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  task automatic step(input logic f, input logic v, input logic [31:0] d, input logic s);
    flush = f;
    wr_if.wr_valid = v;
    wr_if.wr_data = d;
    shift_up = s;
    mdl_step(f, v, d, s);
    @(posedge clk);
    #1;
    flush = 1'b0;
    wr_if.wr_valid = 1'b0;
    shift_up = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    shift_up = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data = '0;
    rd_col = '0;
    mdl_clear();
    #3;
    checks++;
    if (rows_full !== 3'd0) begin
      failures++; $display("FAIL reset_rows_full: got %0d expected 0", rows_full);
    end
    checks++;
    if (win_valid !== 1'b0 || wr_if.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_flags: got valid=%b ready=%b expected 0/1", win_valid, wr_if.wr_ready);
    end
    checks++;
    if (rd_window !== 128'h0) begin
      failures++; $display("FAIL reset_window: got %h expected 0", rd_window);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    logic [31:0] w;
    for (int i = 0; i < 16; i++) begin
      w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      step(1'b0, 1'b1, w, 1'b0);
      checks++;
      if (rows_full !== 3'((i + 1) / 4)) begin
        failures++;
        $display("FAIL fill_rows_full[%0d]: got %0d expected %0d", i, rows_full, (i + 1) / 4);
      end
      checks++;
      if (wr_if.wr_ready !== (i < 15)) begin
        failures++;
        $display("FAIL fill_ready[%0d]: got %b expected %b", i, wr_if.wr_ready, i < 15);
      end
    end
    rd_col = 4'd0;
    #1;
    checks++;
    if (win_valid !== 1'b1) begin
      failures++; $display("FAIL fill_win_valid: got %b expected 1", win_valid);
    end
    checks++;
    if (rd_window[31:0] !== 32'h03020100) begin
      failures++; $display("FAIL fill_row0_col0: got %h expected 03020100", rd_window[31:0]);
    end
    checks++;
    if (rd_window !== exp_win(0)) begin
      failures++; $display("FAIL fill_window: got %h expected %h", rd_window, exp_win(0));
    end
  endtask

  task automatic test_shift();
    step(1'b0, 1'b0, 32'h0, 1'b1);
    rd_col = 4'd0;
    #1;
    checks++;
    if (rows_full !== 3'd3 || win_valid !== 1'b0 || wr_if.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL shift_flags: got rows=%0d valid=%b ready=%b expected 3/0/1",
               rows_full, win_valid, wr_if.wr_ready);
    end
    checks++;
    if (rd_window[31:0] !== 32'h13121110) begin
      failures++; $display("FAIL shift_row0: got %h expected 13121110", rd_window[31:0]);
    end
    checks++;
    if (rd_window !== exp_win(0)) begin
      failures++; $display("FAIL shift_window: got %h expected %h", rd_window, exp_win(0));
    end
  endtask

  task automatic test_write_with_shift();
    logic [31:0] w, w2;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom, 1'b0);
    w = $urandom;
    step(1'b0, 1'b1, w, 1'b1);
    rd_col = 4'd12;
    #1;
    checks++;
    if (rows_full !== 3'd3) begin
      failures++; $display("FAIL ws_rows_full: got %0d expected 3", rows_full);
    end
    checks++;
    if (rd_window[2*32 +: 32] !== swap32(w)) begin
      failures++;
      $display("FAIL ws_row2_tail: got %h expected %h", rd_window[2*32 +: 32], swap32(w));
    end
    checks++;
    if (rd_window !== exp_win(12)) begin
      failures++; $display("FAIL ws_window: got %h expected %h", rd_window, exp_win(12));
    end
    // Pointer must have wrapped to 0: next word opens row 3.
    w2 = $urandom;
    step(1'b0, 1'b1, w2, 1'b0);
    rd_col = 4'd0;
    #1;
    checks++;
    if (rd_window[3*32 +: 32] !== swap32(w2)) begin
      failures++;
      $display("FAIL ws_next_row3: got %h expected %h", rd_window[3*32 +: 32], swap32(w2));
    end
  endtask

  task automatic test_col_overrun();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom, 1'b0);
    rd_col = 4'd14;
    #1;
    checks++;
    if (win_valid !== 1'b1) begin
      failures++; $display("FAIL ovr_full: got %b expected 1", win_valid);
    end
    checks++;
`ifdef WLB_ZERO_PAD_EN
    if (rd_window[31:16] !== 16'h0000) begin
      failures++; $display("FAIL ovr_pad: got %h expected 0000", rd_window[31:16]);
    end
`else
    if (rd_window[31:16] !== {m[0][1], m[0][0]}) begin
      failures++;
      $display("FAIL ovr_wrap: got %h expected %h", rd_window[31:16], {m[0][1], m[0][0]});
    end
`endif
    checks++;
    if (rd_window !== exp_win(14)) begin
      failures++; $display("FAIL ovr_window: got %h expected %h", rd_window, exp_win(14));
    end
  endtask

  task automatic test_flush();
    logic [31:0] w;
    step(1'b1, 1'b1, $urandom, 1'b1);
    rd_col = 4'd0;
    #1;
    checks++;
    if (rows_full !== 3'd0 || win_valid !== 1'b0 || wr_if.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_flags: got rows=%0d valid=%b ready=%b expected 0/0/1",
               rows_full, win_valid, wr_if.wr_ready);
    end
    checks++;
    if (rd_window !== exp_win(0)) begin
      failures++; $display("FAIL flush_data_kept: got %h expected %h", rd_window, exp_win(0));
    end
    w = $urandom;
    step(1'b0, 1'b1, w, 1'b0);
    #1;
    checks++;
    if (rd_window[31:0] !== swap32(w)) begin
      failures++; $display("FAIL flush_ptr0: got %h expected %h", rd_window[31:0], swap32(w));
    end
  endtask

  task automatic test_shift_empty();
    logic [31:0] w;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    rd_col = 4'd0;
    #1;
    checks++;
    if (rows_full !== 3'd0 || rd_window !== exp_win(0)) begin
      failures++;
      $display("FAIL shift_empty: got rows=%0d win=%h expected 0 %h", rows_full, rd_window,
               exp_win(0));
    end
    w = $urandom;
    step(1'b0, 1'b1, w, 1'b0);
    rd_col = 4'd4;
    #1;
    checks++;
    if (rd_window[31:0] !== swap32(w)) begin
      failures++;
      $display("FAIL shift_empty_ptr: got %h expected %h", rd_window[31:0], swap32(w));
    end
  endtask

  task automatic test_random();
    logic f, v, s;
    logic [31:0] d;
    int col;
    for (int n = 0; n < 400; n++) begin
      f = ($urandom_range(0, 29) == 0);
      v = $urandom_range(0, 3) != 0;
      s = ($urandom_range(0, 4) == 0);
      d = $urandom;
      step(f, v, d, s);
      col = $urandom_range(0, RB - 1);
      rd_col = 4'(col);
      #1;
      checks++;
      if (rows_full !== 3'(m_rows) || win_valid !== (m_rows == ROWS) ||
          wr_if.wr_ready !== (m_rows < ROWS)) begin
        failures++;
        $display("FAIL rand_flags[%0d]: got rows=%0d valid=%b ready=%b expected rows=%0d",
                 n, rows_full, win_valid, wr_if.wr_ready, m_rows);
      end
      checks++;
      if (rd_window !== exp_win(col)) begin
        failures++;
        $display("FAIL rand_window[%0d] col=%0d: got %h expected %h", n, col, rd_window,
                 exp_win(col));
      end
    end
  endtask

  task automatic test_rst_mid();
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, $urandom, 1'b0);
    step(1'b0, 1'b1, $urandom, 1'b0);
    @(negedge clk);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data = $urandom;
    #2;
    rst = 1'b1;
    mdl_clear();
    #1;
    checks++;
    if (rows_full !== 3'd0 || win_valid !== 1'b0 || wr_if.wr_ready !== 1'b1 ||
        rd_window !== 128'h0) begin
      failures++;
      $display("FAIL rst_mid_async: got rows=%0d valid=%b ready=%b win=%h expected reset",
               rows_full, win_valid, wr_if.wr_ready, rd_window);
    end
    @(posedge clk);
    @(negedge clk);
    wr_if.wr_valid = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < RB; c += 4) begin
      rd_col = 4'(c);
      #1;
      checks++;
      if (rd_window !== 128'h0 || rows_full !== 3'd0) begin
        failures++;
        $display("FAIL rst_mid_held col=%0d: got rows=%0d win=%h expected 0", c, rows_full,
                 rd_window);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_shift();
    test_write_with_shift();
    test_col_overrun();
    test_flush();
    test_shift_empty();
    test_random();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
